// File: rtl/adc_mux_sequencer_if.sv
// Handshake/bus bundle between the ADC mux sequencer and its surroundings.
// slave = sequencer side, master = controller / ADC-engine side.
interface adc_mux_sequencer_if #(
  parameter int NUM_CH   = 8,
  parameter int SEL_W    = $clog2(NUM_CH),
  parameter int SETTLE_W = 16
);
  logic                enable;
  logic                trigger;
  logic [NUM_CH-1:0]   ch_mask;
  logic [SETTLE_W-1:0] settle_cycles;
  logic [SEL_W-1:0]    mux_sel;
  logic                mux_en;
  logic                conv_req;
  logic                conv_ack;
  logic [SEL_W-1:0]    conv_ch;
  logic                busy;
  logic                seq_done;
  logic                overrun;
  logic [15:0]         overrun_cnt;

  modport slave (
    input  enable, trigger, ch_mask, settle_cycles, conv_ack,
    output mux_sel, mux_en, conv_req, conv_ch, busy, seq_done, overrun, overrun_cnt
  );

  modport master (
    output enable, trigger, ch_mask, settle_cycles, conv_ack,
    input  mux_sel, mux_en, conv_req, conv_ch, busy, seq_done, overrun, overrun_cnt
  );
endinterface

// File: rtl/adc_mux_sequencer.sv
// Analog mux scan sequencer: break-before-make, settle, then convert each masked channel.
// Define ADC_MUX_SEQ_OVERRUN_CNT_EN to build the saturating overrun counter.
module adc_mux_sequencer #(
  parameter int NUM_CH   = 8,
  parameter int SEL_W    = $clog2(NUM_CH),
  parameter int SETTLE_W = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  adc_mux_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_BBM, S_SETTLE, S_CONVERT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                mux_en_q, mux_en_d;
  logic                conv_req_q, conv_req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                abort_q, abort_d;
  logic                xfer;

  function automatic logic [SEL_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (m[i]) lowest = SEL_W'(i);
  endfunction

  assign xfer = conv_req_q & bus.conv_ack;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    ovr_d   = bus.trigger & (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (bus.trigger && bus.enable && (bus.ch_mask != '0)) begin
          state_d = S_BBM;
          sel_d   = lowest(bus.ch_mask);
          mask_d  = bus.ch_mask & ~(NUM_CH'(1) << lowest(bus.ch_mask));
          abort_d = 1'b0;
        end
      end
      S_BBM: begin
        if (!bus.enable) state_d = S_IDLE;
        else begin
          state_d = S_SETTLE;
          // counter runs down to zero, so a programmed 0 still gives one cycle
          cnt_d   = (bus.settle_cycles == '0) ? '0 : bus.settle_cycles - 1'b1;
        end
      end
      S_SETTLE: begin
        if (!bus.enable)      state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_CONVERT;
        else                  cnt_d   = cnt_q - 1'b1;
      end
      S_CONVERT: begin
        // a disable during conversion is remembered; the ADC handshake must still finish
        if (!bus.enable) abort_d = 1'b1;
        if (xfer) begin
          if (!bus.enable || abort_q) state_d = S_IDLE;
          else if (mask_q != '0) begin
            state_d = S_BBM;
            sel_d   = lowest(mask_q);
            mask_d  = mask_q & ~(NUM_CH'(1) << lowest(mask_q));
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    mux_en_d   = (state_d == S_SETTLE) || (state_d == S_CONVERT);
    conv_req_d = (state_d == S_CONVERT);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      mux_en_q   <= 1'b0;
      conv_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      mux_en_q   <= mux_en_d;
      conv_req_q <= conv_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.mux_sel  = sel_q;
  assign bus.mux_en   = mux_en_q;
  assign bus.conv_req = conv_req_q;
  assign bus.conv_ch  = sel_q;
  assign bus.busy     = busy_q;
  assign bus.seq_done = done_q;
  assign bus.overrun  = ovr_q;

`ifdef ADC_MUX_SEQ_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt_q, overrun_cnt_d;

  always_comb begin
    overrun_cnt_d = overrun_cnt_q;
    if (ovr_d && (overrun_cnt_q != 16'hFFFF)) overrun_cnt_d = overrun_cnt_q + 16'd1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) overrun_cnt_q <= '0;
    else          overrun_cnt_q <= overrun_cnt_d;
  end

  assign bus.overrun_cnt = overrun_cnt_q;
`else
  assign bus.overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_adc_mux_sequencer.sv
// Directed self-checking bench for adc_mux_sequencer (NUM_CH=8).
module tb_adc_mux_sequencer;
  logic aclk = 1'b0;
  logic aresetn;
  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  adc_mux_sequencer_if #(.NUM_CH(8)) bus ();
  adc_mux_sequencer #(.NUM_CH(8)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  logic [26:0] outs;
  assign outs = {bus.mux_sel, bus.mux_en, bus.conv_req, bus.conv_ch, bus.busy,
                 bus.seq_done, bus.overrun, bus.overrun_cnt};

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  // trigger high for one cycle; returns at the first sample after it (T+1)
  task automatic pulse_trigger();
    bus.trigger = 1'b1; tick(); bus.trigger = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; tick(); tick();
    checks++;
    if (outs !== 27'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    aresetn = 1'b1; tick();
    checks++;
    if (outs !== 27'd0) begin errors++; $display("FAIL reset_idle: got %h expected 0", outs); end
  endtask

  task automatic test_scan_order();
    logic [2:0] exp_ch [4];
    logic [2:0] ec;
    int ph;
    exp_ch = '{3'd0, 3'd2, 3'd5, 3'd7};
    bus.ch_mask = 8'hA5; bus.settle_cycles = 16'd3; bus.conv_ack = 1'b1;
    pulse_trigger();
    bus.ch_mask = 8'h5A;  // must not disturb the latched scan
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) tick();
      ph = (i - 1) % 5;
      ec = exp_ch[(i - 1) / 5];
      checks++;
      if ({bus.mux_sel, bus.mux_en, bus.conv_req, bus.busy, bus.seq_done} !==
          {ec, ph != 0, ph == 4, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL scan_step%0d: got sel=%0d en=%b req=%b busy=%b done=%b expected sel=%0d en=%b req=%b busy=1 done=0",
                 i, bus.mux_sel, bus.mux_en, bus.conv_req, bus.busy, bus.seq_done, ec, ph != 0, ph == 4);
      end
      if (ph == 4) begin
        checks++;
        if (bus.conv_ch !== ec) begin errors++; $display("FAIL scan_conv_ch%0d: got %0d expected %0d", i, bus.conv_ch, ec); end
      end
    end
    tick();
    checks++;
    if ({bus.seq_done, bus.mux_en, bus.mux_sel, bus.busy, bus.conv_req} !== {1'b1, 1'b0, 3'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL scan_done: got done=%b en=%b sel=%0d busy=%b expected 1 0 7 1", bus.seq_done, bus.mux_en, bus.mux_sel, bus.busy);
    end
    tick();
    checks++;
    if ({bus.seq_done, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL scan_idle: got done=%b busy=%b expected 0 0", bus.seq_done, bus.busy);
    end
  endtask

  task automatic test_zero_settle();
    bus.ch_mask = 8'h01; bus.settle_cycles = 16'd0; bus.conv_ack = 1'b1;
    pulse_trigger();
    checks++;
    if ({bus.busy, bus.mux_en, bus.conv_req} !== 3'b100) begin errors++; $display("FAIL zs_bbm: got %b expected 100", {bus.busy, bus.mux_en, bus.conv_req}); end
    tick();
    checks++;
    if ({bus.mux_en, bus.conv_req} !== 2'b10) begin errors++; $display("FAIL zs_settle: got %b expected 10", {bus.mux_en, bus.conv_req}); end
    tick();
    checks++;
    if ({bus.conv_req, bus.conv_ch} !== {1'b1, 3'd0}) begin errors++; $display("FAIL zs_req_t3: got req=%b ch=%0d expected 1 0", bus.conv_req, bus.conv_ch); end
    tick();
    checks++;
    if ({bus.seq_done, bus.conv_req} !== 2'b10) begin errors++; $display("FAIL zs_done: got %b expected 10", {bus.seq_done, bus.conv_req}); end
    tick();
  endtask

  task automatic test_ack_stall();
    bus.ch_mask = 8'h06; bus.settle_cycles = 16'd1; bus.conv_ack = 1'b0;
    pulse_trigger(); tick(); tick();
    checks++;
    if ({bus.conv_req, bus.conv_ch} !== {1'b1, 3'd1}) begin errors++; $display("FAIL stall_enter: got req=%b ch=%0d expected 1 1", bus.conv_req, bus.conv_ch); end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({bus.conv_req, bus.conv_ch, bus.mux_sel, bus.mux_en} !== {1'b1, 3'd1, 3'd1, 1'b1}) begin
        errors++; $display("FAIL stall_hold%0d: got req=%b ch=%0d expected 1 1", i, bus.conv_req, bus.conv_ch);
      end
    end
    bus.conv_ack = 1'b1; tick();
    checks++;
    if ({bus.conv_req, bus.mux_en, bus.mux_sel} !== {1'b0, 1'b0, 3'd2}) begin
      errors++; $display("FAIL stall_resume: got req=%b en=%b sel=%0d expected 0 0 2", bus.conv_req, bus.mux_en, bus.mux_sel);
    end
    tick(); tick();
    checks++;
    if ({bus.conv_req, bus.conv_ch} !== {1'b1, 3'd2}) begin errors++; $display("FAIL stall_ch2: got req=%b ch=%0d expected 1 2", bus.conv_req, bus.conv_ch); end
    tick();
    checks++;
    if (bus.seq_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", bus.seq_done); end
    bus.conv_ack = 1'b0; tick();
  endtask

  task automatic test_overrun();
    aresetn = 1'b0; tick(); aresetn = 1'b1; tick();
    bus.ch_mask = 8'h0F; bus.settle_cycles = 16'd1; bus.conv_ack = 1'b1;
    pulse_trigger();
    for (int s = 1; s <= 13; s++) begin
      checks++;
      if (bus.overrun !== ((s >= 3) && (s % 2 == 1))) begin
        errors++; $display("FAIL overrun_s%0d: got %b expected %b", s, bus.overrun, (s >= 3) && (s % 2 == 1));
      end
      if (s == 13) begin
        checks++;
        if ({bus.busy, bus.seq_done} !== 2'b11) begin errors++; $display("FAIL overrun_done: got %b expected 11", {bus.busy, bus.seq_done}); end
      end
      bus.trigger = (s % 2 == 0) && (s <= 12);
      tick();
    end
    bus.trigger = 1'b0;
    checks++;
    if ({bus.overrun, bus.busy} !== 2'b00) begin errors++; $display("FAIL overrun_end: got %b expected 00", {bus.overrun, bus.busy}); end
`ifdef ADC_MUX_SEQ_OVERRUN_CNT_EN
    checks++;
    if (bus.overrun_cnt !== 16'd6) begin errors++; $display("FAIL overrun_cnt: got %0d expected 6", bus.overrun_cnt); end
    dut.overrun_cnt_q = 16'hFFFE;
    bus.ch_mask = 8'h01; bus.conv_ack = 1'b0;
    pulse_trigger(); tick(); tick();
    bus.trigger = 1'b1; tick(); tick(); tick(); bus.trigger = 1'b0; tick();
    checks++;
    if (bus.overrun_cnt !== 16'hFFFF) begin errors++; $display("FAIL overrun_sat: got %h expected ffff", bus.overrun_cnt); end
    bus.conv_ack = 1'b1; tick(); tick(); bus.conv_ack = 1'b0;
`else
    checks++;
    if (bus.overrun_cnt !== 16'd0) begin errors++; $display("FAIL overrun_cnt_off: got %0d expected 0", bus.overrun_cnt); end
`endif
  endtask

  task automatic test_abort();
    bus.ch_mask = 8'h01; bus.settle_cycles = 16'd5; bus.conv_ack = 1'b0;
    pulse_trigger(); tick();
    bus.enable = 1'b0; tick();
    checks++;
    if ({bus.busy, bus.mux_en, bus.seq_done} !== 3'b000) begin errors++; $display("FAIL abort_settle: got %b expected 000", {bus.busy, bus.mux_en, bus.seq_done}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.busy, bus.seq_done} !== 2'b00) begin errors++; $display("FAIL abort_quiet%0d: got %b expected 00", i, {bus.busy, bus.seq_done}); end
    end
    bus.enable = 1'b1;
    // disable during CONVERT: handshake completes, then idle without seq_done
    bus.ch_mask = 8'h03; bus.settle_cycles = 16'd1;
    pulse_trigger(); tick(); tick();
    bus.enable = 1'b0; tick(); tick();
    checks++;
    if ({bus.conv_req, bus.busy} !== 2'b11) begin errors++; $display("FAIL abort_conv_hold: got %b expected 11", {bus.conv_req, bus.busy}); end
    bus.conv_ack = 1'b1; tick();
    checks++;
    if ({bus.busy, bus.conv_req, bus.mux_en, bus.seq_done} !== 4'b0000) begin
      errors++; $display("FAIL abort_conv_idle: got %b expected 0000", {bus.busy, bus.conv_req, bus.mux_en, bus.seq_done});
    end
    bus.conv_ack = 1'b0; bus.enable = 1'b1; tick();
    // reset wins over a same-cycle transfer
    bus.ch_mask = 8'h08;
    pulse_trigger(); tick(); tick();
    checks++;
    if ({bus.conv_req, bus.conv_ch} !== {1'b1, 3'd3}) begin errors++; $display("FAIL rst_pre: got req=%b ch=%0d expected 1 3", bus.conv_req, bus.conv_ch); end
    bus.conv_ack = 1'b1; aresetn = 1'b0; tick();
    checks++;
    if (outs !== 27'd0) begin errors++; $display("FAIL rst_conv: got %h expected 0", outs); end
    aresetn = 1'b1; bus.conv_ack = 1'b0; tick();
  endtask

  task automatic test_ignored();
    bus.ch_mask = 8'h00;
    pulse_trigger();
    checks++;
    if ({bus.busy, bus.overrun} !== 2'b00) begin errors++; $display("FAIL ign_mask0: got %b expected 00", {bus.busy, bus.overrun}); end
    tick();
    checks++;
    if ({bus.busy, bus.overrun} !== 2'b00) begin errors++; $display("FAIL ign_mask0_late: got %b expected 00", {bus.busy, bus.overrun}); end
    bus.ch_mask = 8'h01; bus.enable = 1'b0;
    pulse_trigger();
    checks++;
    if ({bus.busy, bus.overrun} !== 2'b00) begin errors++; $display("FAIL ign_disabled: got %b expected 00", {bus.busy, bus.overrun}); end
    bus.enable = 1'b1; tick();
  endtask

  initial begin
    aresetn = 1'b0;
    bus.enable = 1'b1; bus.trigger = 1'b0; bus.ch_mask = '0;
    bus.settle_cycles = '0; bus.conv_ack = 1'b0;
    test_reset();
    test_scan_order();
    test_zero_settle();
    test_ack_stall();
    test_overrun();
    test_abort();
    test_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
